// File: rtl/axi4_stream_rr_arbiter.sv
// AXI4-Stream round-robin packet arbiter.
//
// Merges NUM_IN AXI4-Stream inputs onto one output stream, one whole packet
// at a time. An input holds the grant from its first beat until its tlast beat.
// The next packet is then chosen round-robin, starting the search at the input
// after the one that finished last. The output is a single register stage.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous reset, active low
//   s_tvalid  - per-input valid                      [NUM_IN]
//   s_tready  - per-input ready                      [NUM_IN]
//   s_tdata   - per-input data, input i at [i*DATA_W +: DATA_W]
//   s_tkeep   - per-input keep, input i at [i*KEEP_W +: KEEP_W]
//   s_tlast   - per-input end of packet              [NUM_IN]
//   m_tvalid / m_tready / m_tdata / m_tkeep / m_tlast - shared output stream
//   m_tid     - index of the input that sourced the current output beat
//   busy      - high while a packet holds the grant
module axi4_stream_rr_arbiter #(
    parameter int  BUS_WIDTH = 32,
    parameter int  NUM_IN    = 4,
    localparam int DATA_W    = ((BUS_WIDTH - 1) / 8 + 1) * 8,
    localparam int KEEP_W    = DATA_W / 8,
    localparam int ID_W      = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        s_tvalid,
    output logic [NUM_IN-1:0]        s_tready,
    input  logic [NUM_IN*DATA_W-1:0] s_tdata,
    input  logic [NUM_IN*KEEP_W-1:0] s_tkeep,
    input  logic [NUM_IN-1:0]        s_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic [KEEP_W-1:0]        m_tkeep,
    output logic                     m_tlast,
    output logic [ID_W-1:0]          m_tid,
    output logic                     busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   grant_reg, grant_next;
    logic [ID_W-1:0]   last_grant_reg, last_grant_next;

    logic              m_tvalid_reg, m_tvalid_next;
    logic [DATA_W-1:0] m_tdata_reg, m_tdata_next;
    logic [KEEP_W-1:0] m_tkeep_reg, m_tkeep_next;
    logic              m_tlast_reg, m_tlast_next;
    logic [ID_W-1:0]   m_tid_reg, m_tid_next;

    logic [DATA_W-1:0] in_data [NUM_IN];
    logic [KEEP_W-1:0] in_keep [NUM_IN];

    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   scan_idx;
    logic              found;
    logic              out_free;
    logic              accept;

    // Unpack the flat input buses into per-input arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign in_data[gi] = s_tdata[gi*DATA_W +: DATA_W];
            assign in_keep[gi] = s_tkeep[gi*KEEP_W +: KEEP_W];
        end
    endgenerate

    // The output register can take a beat when it is empty or being drained.
    assign out_free = !m_tvalid_reg || m_tready;

    // Only the granted input sees ready, and only while a packet is locked.
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
            assign s_tready[gi] = (state_reg == LOCKED) &&
                                  (grant_reg == ID_W'(gi)) && out_free;
        end
    endgenerate

    assign accept = (state_reg == LOCKED) && s_tvalid[grant_reg] && out_free;

    // Round-robin search: first requester at last_grant+1, +2, ... (mod NUM_IN).
    // The previous winner is visited last, which keeps every input from starving.
    always_comb begin
        pick     = last_grant_reg;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            scan_idx = ID_W'((int'(last_grant_reg) + k) % NUM_IN);
            if (!found && s_tvalid[scan_idx]) begin
                pick  = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        m_tvalid_next   = m_tvalid_reg;
        m_tdata_next    = m_tdata_reg;
        m_tkeep_next    = m_tkeep_reg;
        m_tlast_next    = m_tlast_reg;
        m_tid_next      = m_tid_reg;

        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_next = pick;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                // The grant is released only by the tlast beat; gaps in the
                // granted input's valid just stall the packet.
                if (accept && s_tlast[grant_reg]) begin
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (accept) begin
            m_tvalid_next = 1'b1;
            m_tdata_next  = in_data[grant_reg];
            m_tkeep_next  = in_keep[grant_reg];
            m_tlast_next  = s_tlast[grant_reg];
            m_tid_next    = grant_reg;
        end else if (m_tready) begin
            m_tvalid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= ID_W'(NUM_IN - 1);
            m_tvalid_reg   <= 1'b0;
            m_tdata_reg    <= '0;
            m_tkeep_reg    <= '0;
            m_tlast_reg    <= 1'b0;
            m_tid_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            m_tvalid_reg   <= m_tvalid_next;
            m_tdata_reg    <= m_tdata_next;
            m_tkeep_reg    <= m_tkeep_next;
            m_tlast_reg    <= m_tlast_next;
            m_tid_reg      <= m_tid_next;
        end
    end

    assign m_tvalid = m_tvalid_reg;
    assign m_tdata  = m_tdata_reg;
    assign m_tkeep  = m_tkeep_reg;
    assign m_tlast  = m_tlast_reg;
    assign m_tid    = m_tid_reg;
    assign busy     = (state_reg == LOCKED);

endmodule

// File: doc/axi4_stream_rr_arbiter.md
AXI4_STREAM_RR_ARBITER -- requirements
Module: axi4_stream_rr_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: payload width in bits, rounded up to whole bytes, giving DATA_W = ((BUS_WIDTH-1)/8+1)*8 and KEEP_W = DATA_W/8.
REQ-002 SHALL have parameter NUM_IN, default 4, legal range 2..16: number of stream inputs.
REQ-003 SHALL define ID_W = max(1, clog2(NUM_IN)).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port s_tvalid, input, NUM_IN bits: per-input valid.
REQ-007 SHALL have port s_tready, output, NUM_IN bits: per-input ready.
REQ-008 SHALL have port s_tdata, input, NUM_IN*DATA_W bits: input i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port s_tkeep, input, NUM_IN*KEEP_W bits, packed in the same way as s_tdata.
REQ-010 SHALL have port s_tlast, input, NUM_IN bits: per-input end of packet.
REQ-011 SHALL have ports m_tvalid (out, 1), m_tready (in, 1), m_tdata (out, DATA_W), m_tkeep (out, KEEP_W) and m_tlast (out, 1): the shared output stream.
REQ-012 SHALL have port m_tid, output, ID_W bits: index of the input that sourced the current m_* beat.
REQ-013 SHALL have port busy, output, 1 bit: high while in state LOCKED.

Function
REQ-014 SHALL use a two-state FSM with states IDLE and LOCKED, plus a grant register and a round-robin pointer last_grant.
REQ-015 In IDLE, when any s_tvalid bit is high, the block SHALL register as grant the first requester found searching from last_grant+1 upward, modulo NUM_IN, and SHALL enter LOCKED on the next edge.
REQ-016 In IDLE, all s_tready bits SHALL be 0, so no beat is accepted in the arbitration cycle.
REQ-017 In LOCKED, s_tready[grant] SHALL equal (!m_tvalid || m_tready), and every other s_tready bit SHALL be 0.
REQ-018 A beat SHALL be accepted when s_tvalid[grant] and s_tready[grant] are both high.
REQ-019 On an accepted beat, m_tdata, m_tkeep, m_tlast and m_tid SHALL be loaded with the granted input's fields and the grant index on the same edge, and m_tvalid SHALL be set to 1.
REQ-020 Latency from input acceptance to m_* presentation SHALL be 1 cycle.
REQ-021 The block SHALL sustain one beat per cycle within a packet while m_tready stays high.
REQ-022 When m_tvalid=1, m_tready=1 and no new beat is accepted, m_tvalid SHALL clear to 0 on the next edge.
REQ-023 While m_tvalid=1 and m_tready=0, all m_* outputs SHALL hold stable.
REQ-024 An accepted beat with s_tlast=1 SHALL set last_grant to grant and return the FSM to IDLE on the same edge.
REQ-025 The grant SHALL NOT change mid-packet: if s_tvalid[grant] deasserts mid-packet, the block SHALL stay LOCKED and wait.
REQ-026 Valid requests from non-granted inputs SHALL NOT affect the current packet.
REQ-027 Per-packet overhead SHALL be exactly one IDLE cycle; this IDLE cycle MAY overlap draining of the output register.
REQ-028 A single-beat packet (tlast on its first beat) SHALL be legal and handled the same as any other packet.
REQ-029 Arbitration SHALL be starvation-free: with all inputs requesting continuously, packets SHALL be granted in order 0,1,2,...,NUM_IN-1,0,...
REQ-030 Data SHALL pass through unmodified; tkeep SHALL NOT be checked or altered.

Reset
REQ-031 While rst=0, the block SHALL force FSM=IDLE, grant=0, last_grant=NUM_IN-1, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, m_tid=0, s_tready=0 and busy=0, asynchronously.
REQ-032 Reset asserted mid-packet SHALL discard the in-flight packet and any beat held in the output register, with no partial-packet recovery after release.
REQ-033 After reset release, input 0 SHALL have the highest priority.

Verification
REQ-034 Bench SHALL cover: inputs 0 and 2 each offer a 3-beat packet, m_tready=1 -> m_tid sequence 0,0,0,2,2,2; m_tlast on beats 3 and 6; one bubble between the packets.
REQ-035 Bench SHALL cover: all 4 inputs continuously offer 1-beat packets -> m_tid = 0,1,2,3,0,1 on successive output beats.
REQ-036 Bench SHALL cover: m_tready held at 0 for 5 cycles mid-packet -> m_tdata and m_tid stable; s_tready[grant]=0; no beat lost or duplicated.
REQ-037 Bench SHALL cover: s_tvalid[1] drops for 3 cycles mid-packet while input 3 requests -> busy stays 1; no input-3 beat appears before input 1's tlast.
REQ-038 Bench SHALL cover: rst driven low during beat 2 of a 4-beat packet -> m_tvalid=0 immediately; after release, input 0 requesting is granted first.
REQ-039 Bench SHALL cover: random valid/ready on all inputs for 10k cycles -> a scoreboard sees per-input packet order preserved and no interleaving within any packet.
